// File: rtl/async_fifo_wr_arb_if.sv
// rtl/async_fifo_wr_arb_if.sv - source request bus and FIFO write port of the write-side arbiter
interface async_fifo_wr_arb_if #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int AW = 9
);
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           fifo_wrreq;
  logic [W-1:0]   fifo_wrdin;
  logic           fifo_wrfull;
  logic [AW-1:0]  fifo_wrusedw;

  // The arbiter owns the FIFO write port, so it is the master side.
  modport master (
    input  req_valid, req_data, req_last, fifo_wrfull, fifo_wrusedw,
    output req_ready, fifo_wrreq, fifo_wrdin
  );

  modport slave (
    output req_valid, req_data, req_last, fifo_wrfull, fifo_wrusedw,
    input  req_ready, fifo_wrreq, fifo_wrdin
  );
endinterface

// File: rtl/async_fifo_wr_arb.sv
// rtl/async_fifo_wr_arb.sv - packet-granular round-robin arbiter for one async FIFO write port
module async_fifo_wr_arb #(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int DEPTH    = 512,
  parameter int MIN_ROOM = 16,
  parameter int HDR_EN   = 1,
  localparam int AW      = $clog2(DEPTH),
  localparam int GW      = $clog2(N)
) (
  input  logic                rst_n,
  input  logic                wrclk,
  async_fifo_wr_arb_if.master bus,
  output logic [GW-1:0]       grant_id,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [AW-1:0] ROOM_MAX = AW'(DEPTH - 1 - MIN_ROOM);

  state_t        r_state;
  logic [GW-1:0] r_grant;
  logic [GW-1:0] r_last_grant;
  logic          r_busy;

  logic          w_room_ok;
  logic          w_any;
  logic [GW-1:0] w_pick;

  // usedw wraps to 0 when the FIFO is full, so the full flag must gate it.
  assign w_room_ok = ~bus.fifo_wrfull & (bus.fifo_wrusedw <= ROOM_MAX);

  always_comb begin : rr_pick
    int idx;
    idx    = 0;
    w_any  = 1'b0;
    w_pick = r_last_grant;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(r_last_grant) + k) % N;
      if (!w_any && bus.req_valid[GW'(idx)]) begin
        w_any  = 1'b1;
        w_pick = GW'(idx);
      end
    end
  end

  always_ff @(posedge wrclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_last_grant <= GW'(N - 1);
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any && w_room_ok) begin
            r_grant      <= w_pick;
            r_last_grant <= w_pick;
            r_state      <= (HDR_EN != 0) ? HDR : DATA;
            r_busy       <= 1'b1;
          end
        end
        HDR: begin
          if (!bus.fifo_wrfull) r_state <= DATA;
        end
        DATA: begin
          // The grant is held across valid gaps until the last beat is written.
          if (bus.fifo_wrreq && bus.req_last[r_grant]) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    bus.req_ready  = '0;
    bus.fifo_wrreq = 1'b0;
    bus.fifo_wrdin = '0;
    case (r_state)
      HDR: begin
        bus.fifo_wrdin           = '1;
        bus.fifo_wrdin[GW-1:0]   = r_grant;
        bus.fifo_wrreq           = ~bus.fifo_wrfull;
      end
      DATA: begin
        bus.req_ready[r_grant] = ~bus.fifo_wrfull;
        bus.fifo_wrreq         = bus.req_valid[r_grant] & ~bus.fifo_wrfull;
        bus.fifo_wrdin         = bus.req_data[int'(r_grant)*W +: W];
      end
      default: begin
      end
    endcase
  end

  assign grant_id = r_grant;
  assign busy     = r_busy;

endmodule
